branch_resolve_unit: RTL and testbench

- Writer-side partner of the fetch-stage branch target buffer (BTB).
- Carries each fetched control-flow instruction's prediction metadata (predicted next PC, 2-bit counter) through the IF/ID and ID/EX shadow registers, alongside the main pipeline.
- Resolves each prediction in EX against the actual outcome and raises mispredict/redirect.
- Produces a registered BTB update: index PC, target, new saturating counter value.

---
 rtl/bp_pkg.sv | 16 +
 rtl/sat_counter_update.sv | 16 +
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 tb/tb_branch_resolve_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-prediction types and defaults for the BTB and its resolve unit
package bp_pkg;

    localparam int XLEN             = 32;
    localparam int CTR_W            = 2;
    localparam int CTR_TAKEN_THRESH = 2;

    typedef struct packed {
        logic             valid;
        logic             is_cf;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pred_pc;
        logic [CTR_W-1:0] pred_ctr;
    } shadow_t;

endpackage

// File: rtl/sat_counter_update.sv
// sat_counter_update: next value of a saturating branch-prediction counter
module sat_counter_update #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             taken,
    output logic [CTR_W-1:0] next_ctr
);

    // step towards taken/not-taken, sticking at all-ones and at zero
    always_comb begin
        next_ctr = taken ? ((&ctr) ? ctr : ctr + 1'b1)
                         : ((|ctr) ? ctr - 1'b1 : ctr);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries BTB predictions to EX, resolves them and emits BTB updates.
// Optional BRU_PERF_CNT_EN adds saturating perf_branches / perf_mispred counters.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int XLEN   = bp_pkg::XLEN,
    parameter int CTR_W  = bp_pkg::CTR_W,
    parameter int PERF_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_is_cf,
    input  logic [XLEN-1:0]  if_pred_pc,
    input  logic [CTR_W-1:0] if_pred_ctr,
    input  logic             stall_id,
    input  logic             stall_ex,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [XLEN-1:0]  upd_pc,
    output logic [XLEN-1:0]  upd_target,
    output logic [CTR_W-1:0] upd_ctr
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispred
`endif
);

    shadow_t          s1, s2;
    logic             resolve;
    logic [XLEN-1:0]  actual_pc;
    logic [CTR_W-1:0] next_ctr;

    sat_counter_update #(.CTR_W(CTR_W)) u_ctr (
        .ctr      (s2.pred_ctr),
        .taken    (ex_taken),
        .next_ctr (next_ctr)
    );

    // IF/ID shadow: squash on mispredict, hold on stall_id, else capture fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s1 <= '0;
        else if (mispredict)
            s1.valid <= 1'b0;
        else if (!stall_id)
            s1 <= '{valid: if_valid, is_cf: if_is_cf, pc: if_pc,
                    pred_pc: if_pred_pc, pred_ctr: if_pred_ctr};
    end

    // ID/EX shadow: hold on stall_ex, bubble on mispredict or stall_id, else advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s2 <= '0;
        else if (stall_ex)
            s2 <= s2;
        else if (mispredict || stall_id)
            s2.valid <= 1'b0;
        else
            s2 <= s1;
    end

    // resolve a control-flow instruction in EX against its real next PC
    always_comb begin
        resolve     = s2.valid && s2.is_cf && !stall_ex;
        actual_pc   = ex_taken ? ex_target : s2.pc + XLEN'(4);
        mispredict  = resolve && (actual_pc != s2.pred_pc);
        redirect_pc = mispredict ? actual_pc : '0;
    end

    // BTB write one cycle after every resolve, right or wrong, so counters train
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            upd_valid  <= 1'b0;
            upd_pc     <= '0;
            upd_target <= '0;
            upd_ctr    <= '0;
        end else begin
            upd_valid <= resolve;
            if (resolve) begin
                upd_pc     <= s2.pc;
                upd_target <= ex_target;
                upd_ctr    <= next_ctr;
            end
        end
    end

`ifdef BRU_PERF_CNT_EN
    // saturating event counters for resolved branches and mispredicts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else begin
            if (resolve && !(&perf_branches))
                perf_branches <= perf_branches + 1'b1;
            if (mispredict && !(&perf_mispred))
                perf_mispred <= perf_mispred + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed and randomized checks of branch_resolve_unit
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        if_is_cf = 1'b0;
    logic [31:0] if_pred_pc = '0;
    logic [1:0]  if_pred_ctr = '0;
    logic        stall_id = 1'b0;
    logic        stall_ex = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [1:0]  upd_ctr;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches;
    logic [31:0] perf_mispred;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk         (clk),
        .reset       (reset),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_is_cf    (if_is_cf),
        .if_pred_pc  (if_pred_pc),
        .if_pred_ctr (if_pred_ctr),
        .stall_id    (stall_id),
        .stall_ex    (stall_ex),
        .ex_taken    (ex_taken),
        .ex_target   (ex_target),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_ctr     (upd_ctr)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches (perf_branches),
        .perf_mispred  (perf_mispred)
`endif
    );

    // fetch one instruction, then advance it into EX; returns at posedge+1
    task automatic issue(input logic [31:0] pc, input logic [31:0] pred, input logic [1:0] ctr);
        if_valid = 1'b1; if_is_cf = 1'b1; if_pc = pc; if_pred_pc = pred; if_pred_ctr = ctr;
        @(posedge clk); #1;
        if_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        total++; if (mispredict !== 1'b0) $display("FAIL rst_mp got %0b exp 0", mispredict); else passed++;
        total++; if (redirect_pc !== 32'h0) $display("FAIL rst_redir got %h exp 0", redirect_pc); else passed++;
        total++; if (upd_valid !== 1'b0) $display("FAIL rst_uv got %0b exp 0", upd_valid); else passed++;
        total++; if ({upd_pc, upd_target, upd_ctr} !== 66'h0) $display("FAIL rst_upd got %h %h %0d exp 0", upd_pc, upd_target, upd_ctr); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (upd_valid !== 1'b0 || mispredict !== 1'b0) $display("FAIL idle_%0d got uv=%0b mp=%0b exp 0 0", i, upd_valid, mispredict); else passed++;
        end
    endtask

    task automatic test_correct_taken();
        issue(32'h100, 32'h200, 2'd2);
        ex_taken = 1'b1; ex_target = 32'h200;
        #1;
        total++; if (mispredict !== 1'b0) $display("FAIL ct_mp got %0b exp 0", mispredict); else passed++;
        @(posedge clk); #1;
        total++; if (upd_valid !== 1'b1) $display("FAIL ct_uv got %0b exp 1", upd_valid); else passed++;
        total++; if (upd_pc !== 32'h100) $display("FAIL ct_pc got %h exp 100", upd_pc); else passed++;
        total++; if (upd_target !== 32'h200) $display("FAIL ct_tgt got %h exp 200", upd_target); else passed++;
        total++; if (upd_ctr !== 2'd3) $display("FAIL ct_ctr got %0d exp 3", upd_ctr); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_mispredict_nt();
        if_valid = 1'b1; if_is_cf = 1'b1; if_pc = 32'h40; if_pred_pc = 32'h80; if_pred_ctr = 2'd3;
        @(posedge clk); #1;
        if_pc = 32'h44; if_pred_pc = 32'h999; if_pred_ctr = 2'd1;
        @(posedge clk); #1;
        if_pc = 32'h48; if_pred_pc = 32'h777;
        ex_taken = 1'b0; ex_target = 32'h80;
        #1;
        total++; if (mispredict !== 1'b1) $display("FAIL mp_mp got %0b exp 1", mispredict); else passed++;
        total++; if (redirect_pc !== 32'h44) $display("FAIL mp_redir got %h exp 44", redirect_pc); else passed++;
        @(posedge clk); #1;
        if_valid = 1'b0;
        ex_taken = 1'b1; ex_target = 32'h1234;
        total++; if (upd_valid !== 1'b1 || upd_ctr !== 2'd2 || upd_pc !== 32'h40) $display("FAIL mp_upd got uv=%0b ctr=%0d pc=%h exp 1 2 40", upd_valid, upd_ctr, upd_pc); else passed++;
        for (int i = 0; i < 2; i++) begin
            total++; if (mispredict !== 1'b0) $display("FAIL mp_squash_mp%0d got %0b exp 0", i, mispredict); else passed++;
            @(posedge clk); #1;
            total++; if (upd_valid !== 1'b0) $display("FAIL mp_squash_uv%0d got %0b exp 0", i, upd_valid); else passed++;
        end
    endtask

    task automatic test_saturation();
        issue(32'h300, 32'h304, 2'd0);
        ex_taken = 1'b0; ex_target = 32'h8888;
        #1;
        total++; if (mispredict !== 1'b0) $display("FAIL sat0_mp got %0b exp 0", mispredict); else passed++;
        @(posedge clk); #1;
        total++; if (upd_valid !== 1'b1 || upd_ctr !== 2'd0) $display("FAIL sat0_ctr got uv=%0b ctr=%0d exp 1 0", upd_valid, upd_ctr); else passed++;
        issue(32'h400, 32'h500, 2'd3);
        ex_taken = 1'b1; ex_target = 32'h500;
        #1;
        total++; if (mispredict !== 1'b0) $display("FAIL sat3_mp got %0b exp 0", mispredict); else passed++;
        @(posedge clk); #1;
        total++; if (upd_valid !== 1'b1 || upd_ctr !== 2'd3 || upd_target !== 32'h500) $display("FAIL sat3_ctr got uv=%0b ctr=%0d tgt=%h exp 1 3 500", upd_valid, upd_ctr, upd_target); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall_ex();
        int pulses;
        issue(32'h600, 32'h604, 2'd1);
        ex_taken = 1'b1; ex_target = 32'h900;
        stall_ex = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (mispredict !== 1'b0) $display("FAIL st_mp%0d got %0b exp 0", i, mispredict); else passed++;
            @(posedge clk); #1;
            total++; if (upd_valid !== 1'b0) $display("FAIL st_uv%0d got %0b exp 0", i, upd_valid); else passed++;
        end
        stall_ex = 1'b0;
        #1;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h900) $display("FAIL st_release got mp=%0b redir=%h exp 1 900", mispredict, redirect_pc); else passed++;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (upd_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 1) $display("FAIL st_pulses got %0d exp 1", pulses); else passed++;
    endtask

    task automatic test_back_to_back_async_reset();
        if_valid = 1'b1; if_is_cf = 1'b1; if_pc = 32'h500; if_pred_pc = 32'h600; if_pred_ctr = 2'd1;
        @(posedge clk); #1;
        if_pc = 32'h600; if_pred_pc = 32'h700; if_pred_ctr = 2'd2;
        @(posedge clk); #1;
        if_valid = 1'b0;
        ex_taken = 1'b1; ex_target = 32'h600;
        #1;
        total++; if (mispredict !== 1'b0) $display("FAIL b2b_a_mp got %0b exp 0", mispredict); else passed++;
        @(posedge clk); #1;
        ex_taken = 1'b0; ex_target = 32'h700;
        #1;
        total++; if (upd_valid !== 1'b1 || upd_pc !== 32'h500 || upd_ctr !== 2'd2) $display("FAIL b2b_a_upd got uv=%0b pc=%h ctr=%0d exp 1 500 2", upd_valid, upd_pc, upd_ctr); else passed++;
        total++; if (mispredict !== 1'b1 || redirect_pc !== 32'h604) $display("FAIL b2b_b_mp got mp=%0b redir=%h exp 1 604", mispredict, redirect_pc); else passed++;
        #1 reset = 1'b1;
        #1;
        total++; if (mispredict !== 1'b0 || redirect_pc !== 32'h0) $display("FAIL arst_mp got mp=%0b redir=%h exp 0 0", mispredict, redirect_pc); else passed++;
        total++; if (upd_valid !== 1'b0) $display("FAIL arst_uv got %0b exp 0", upd_valid); else passed++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] r_pc[400], r_pred[400], r_tg[400];
        logic [1:0]  r_ctr[400];
        logic        r_cf[400], r_tk[400];
        int s1 = -1, s2 = -1, ns1, ns2, ctr_i;
        logic r, emp, ev;
        logic [31:0] a, eredir, epc, etg;
        logic [1:0] ectr;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_pc[n]  = ($urandom % 16 == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            r_cf[n]  = ($urandom % 4 != 0);
            r_tk[n]  = $urandom % 2;
            r_tg[n]  = $urandom & 32'hFFFF_FFFC;
            r_ctr[n] = 2'($urandom % 4);
            r_pred[n] = ($urandom % 3 != 0) ? (r_tk[n] ? r_tg[n] : r_pc[n] + 32'd4) : ($urandom & 32'hFFFF_FFFC);
            if_valid = ($urandom % 4 != 0);
            if_pc = r_pc[n]; if_is_cf = r_cf[n]; if_pred_pc = r_pred[n]; if_pred_ctr = r_ctr[n];
            stall_id = ($urandom % 5 == 0);
            stall_ex = ($urandom % 6 == 0);
            ex_taken  = (s2 >= 0) ? r_tk[s2] : 1'($urandom % 2);
            ex_target = (s2 >= 0) ? r_tg[s2] : $urandom;
            r = (s2 >= 0) && r_cf[s2] && !stall_ex;
            a = (s2 < 0) ? 32'h0 : r_tk[s2] ? r_tg[s2] : r_pc[s2] + 32'd4;
            emp = r && (a != r_pred[s2]);
            eredir = emp ? a : 32'h0;
            #1;
            total++; if (mispredict !== emp || redirect_pc !== eredir) $display("FAIL rnd_mp c%0d got %0b %h exp %0b %h", n, mispredict, redirect_pc, emp, eredir); else passed++;
            ev = r;
            if (r) begin
                epc = r_pc[s2];
                etg = r_tg[s2];
                ctr_i = r_tk[s2] ? int'(r_ctr[s2]) + 1 : int'(r_ctr[s2]) - 1;
                ectr = 2'((ctr_i > 3) ? 3 : (ctr_i < 0) ? 0 : ctr_i);
            end
            ns1 = emp ? -1 : stall_id ? s1 : (if_valid ? n : -1);
            ns2 = stall_ex ? s2 : (emp || stall_id) ? -1 : s1;
            s1 = ns1; s2 = ns2;
            @(posedge clk); #1;
            total++; if (upd_valid !== ev) $display("FAIL rnd_uv c%0d got %0b exp %0b", n, upd_valid, ev); else passed++;
            if (ev) begin
                total++; if (upd_pc !== epc || upd_target !== etg || upd_ctr !== ectr) $display("FAIL rnd_upd c%0d got %h %h %0d exp %h %h %0d", n, upd_pc, upd_target, upd_ctr, epc, etg, ectr); else passed++;
            end
        end
        if_valid = 1'b0; stall_id = 1'b0; stall_ex = 1'b0;
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_mispredict_nt();
        test_saturation();
        test_stall_ex();
        test_back_to_back_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
